// File: rtl/ethernet_initiator_pkg.sv
// Shared definitions for the Ethernet TX MMIO initiator.
// - state_e: FSM state encoding of the initiator.
// - Default controller register offsets; the control unit decodes the
//   same offsets on its responder side.
package ethernet_initiator_pkg;

  typedef enum logic [3:0] {
    ST_IDLE     = 4'd0,
    ST_POLL     = 4'd1,
    ST_POLL_RSP = 4'd2,
    ST_GAP      = 4'd3,
    ST_DATA     = 4'd4,
    ST_DATA_RSP = 4'd5,
    ST_SIZE     = 4'd6,
    ST_SIZE_RSP = 4'd7,
    ST_SEND     = 4'd8,
    ST_SEND_RSP = 4'd9,
    ST_DRAIN    = 4'd10,
    ST_DROP     = 4'd11
  } state_e;

  localparam logic [13:0] TX_STATUS_ADDR_DEF = 14'h0010;
  localparam logic [13:0] TX_SIZE_ADDR_DEF   = 14'h0018;
  localparam logic [13:0] TX_SEND_ADDR_DEF   = 14'h001C;
  localparam logic [13:0] TX_BUF_BASE_DEF    = 14'h1800;

endpackage

// File: rtl/ethernet_poll_timer.sv
// Down-counter that spaces consecutive TX-status polls.
// Ports:
//   clk_i, reset_n_i : clock, async active-low reset
//   load_i           : load the counter with gap_p
//   dec_i            : decrement by one (saturates at zero)
//   zero_o           : counter is zero
module ethernet_poll_timer #(
  parameter int unsigned gap_p = 16
) (
  input  logic clk_i,
  input  logic reset_n_i,
  input  logic load_i,
  input  logic dec_i,
  output logic zero_o
);

  localparam int unsigned cnt_w_lp = (gap_p < 1) ? 1 : $clog2(gap_p + 1);

  logic [cnt_w_lp-1:0] cnt_q, cnt_d;

  // Next count: load has priority over decrement.
  always_comb begin
    cnt_d = cnt_q;
    if (load_i) begin
      cnt_d = cnt_w_lp'(gap_p);
    end else if (dec_i && (cnt_q != '0)) begin
      cnt_d = cnt_q - cnt_w_lp'(1);
    end else begin
      cnt_d = cnt_q;
    end
  end

  // Counter register.
  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign zero_o = (cnt_q == '0);

endmodule

// File: rtl/ethernet_tx_mmio_initiator_chk.sv
// Simulation checker for the initiator's response channel.
// Ports: clk_i, reset_n_i, valid_i (response beat), rsp_ready_i (initiator's ready_and_o).
module ethernet_tx_mmio_initiator_chk (
  input logic clk_i,
  input logic reset_n_i,
  input logic valid_i,
  input logic rsp_ready_i
);

  // A response beat may only arrive while the initiator waits for one.
  property p_no_stray_rsp;
    @(posedge clk_i) disable iff (!reset_n_i) valid_i |-> rsp_ready_i;
  endproperty

  a_no_stray_rsp: assert property (p_no_stray_rsp);

endmodule

// File: rtl/ethernet_tx_mmio_initiator.sv
// MMIO initiator that pushes a packet word stream into the Ethernet
// controller's TX buffer: poll status until free, write the words, write
// the byte length, then trigger the send. Over-MTU packets are dropped.
// Ports:
//   clk_i, reset_n_i                  : clock, async active-low reset
//   pkt_v_i/pkt_data_i/pkt_last_i/
//   pkt_bytes_i/pkt_ready_and_o       : packet word stream in
//   addr_o/write_en_o/read_en_o/
//   ready_and_i/op_size_o/write_data_o: MMIO command out
//   valid_i/ready_and_o/read_data_i   : MMIO response in
//   busy_o, done_o, err_o             : status
module ethernet_tx_mmio_initiator
  import ethernet_initiator_pkg::*;
#(
  parameter int unsigned data_width_p = 32,
  parameter int unsigned eth_mtu_p    = 2048,
  parameter int unsigned addr_width_p = 14,
  parameter int unsigned poll_gap_p   = 16,
  parameter logic [addr_width_p-1:0] tx_status_addr_p = addr_width_p'(TX_STATUS_ADDR_DEF),
  parameter logic [addr_width_p-1:0] tx_size_addr_p   = addr_width_p'(TX_SIZE_ADDR_DEF),
  parameter logic [addr_width_p-1:0] tx_send_addr_p   = addr_width_p'(TX_SEND_ADDR_DEF),
  parameter logic [addr_width_p-1:0] tx_buf_base_p    = addr_width_p'(TX_BUF_BASE_DEF),
  localparam int unsigned bytes_lp   = data_width_p / 8,
  localparam int unsigned bytes_w_lp = $clog2(bytes_lp) + 1,
  localparam int unsigned opsz_w_lp  = $clog2($clog2(bytes_lp) + 1)
) (
  input  logic                    clk_i,
  input  logic                    reset_n_i,
  input  logic                    pkt_v_i,
  input  logic [data_width_p-1:0] pkt_data_i,
  input  logic                    pkt_last_i,
  input  logic [bytes_w_lp-1:0]   pkt_bytes_i,
  output logic                    pkt_ready_and_o,
  output logic [addr_width_p-1:0] addr_o,
  output logic                    write_en_o,
  output logic                    read_en_o,
  input  logic                    ready_and_i,
  output logic [opsz_w_lp-1:0]    op_size_o,
  output logic [data_width_p-1:0] write_data_o,
  input  logic                    valid_i,
  output logic                    ready_and_o,
  input  logic [data_width_p-1:0] read_data_i,
  output logic                    busy_o,
  output logic                    done_o,
  output logic                    err_o
);

  localparam int unsigned cnt_w_lp = $clog2(eth_mtu_p + 1);

  state_e              state_q, state_d;
  logic [cnt_w_lp-1:0] byte_cnt_q, byte_cnt_d;
  logic                last_q, last_d;
  logic                done_q, done_d;
  logic                gap_load_s, gap_dec_s, gap_zero_s;
  logic [cnt_w_lp:0]   sum_s;
  logic                over_s;
  logic                unused_s;

  // Only the free bit of the status word is meaningful.
  assign unused_s = ^read_data_i[data_width_p-1:1];

  // One extra bit so the MTU comparison cannot wrap.
  assign sum_s  = {1'b0, byte_cnt_q} + (cnt_w_lp + 1)'(pkt_bytes_i);
  assign over_s = sum_s > (cnt_w_lp + 1)'(eth_mtu_p);

  ethernet_poll_timer #(
    .gap_p (poll_gap_p)
  ) u_gap_timer (
    .clk_i     (clk_i),
    .reset_n_i (reset_n_i),
    .load_i    (gap_load_s),
    .dec_i     (gap_dec_s),
    .zero_o    (gap_zero_s)
  );

  // Next-state and command/handshake decode.
  always_comb begin
    state_d         = state_q;
    byte_cnt_d      = byte_cnt_q;
    last_d          = last_q;
    done_d          = 1'b0;
    gap_load_s      = 1'b0;
    gap_dec_s       = 1'b0;
    addr_o          = '0;
    write_en_o      = 1'b0;
    read_en_o       = 1'b0;
    write_data_o    = '0;
    ready_and_o     = 1'b0;
    pkt_ready_and_o = 1'b0;
    case (state_q)
      ST_IDLE: begin
        // The first word stays on the input until the buffer is free.
        if (pkt_v_i) state_d = ST_POLL;
        else         state_d = ST_IDLE;
      end
      ST_POLL: begin
        read_en_o = 1'b1;
        addr_o    = tx_status_addr_p;
        if (ready_and_i) state_d = ST_POLL_RSP;
        else             state_d = ST_POLL;
      end
      ST_POLL_RSP: begin
        ready_and_o = 1'b1;
        if (valid_i) begin
          if (read_data_i[0]) begin
            state_d = ST_DATA;
          end else begin
            gap_load_s = 1'b1;
            state_d    = ST_GAP;
          end
        end else begin
          state_d = ST_POLL_RSP;
        end
      end
      ST_GAP: begin
        if (gap_zero_s) begin
          state_d = ST_POLL;
        end else begin
          gap_dec_s = 1'b1;
          state_d   = ST_GAP;
        end
      end
      ST_DATA: begin
        if (pkt_v_i) begin
          if (over_s) begin
            // Word would exceed the MTU: swallow it without writing.
            pkt_ready_and_o = 1'b1;
            state_d         = pkt_last_i ? ST_DROP : ST_DRAIN;
          end else begin
            write_en_o      = 1'b1;
            addr_o          = tx_buf_base_p + addr_width_p'(byte_cnt_q);
            write_data_o    = pkt_data_i;
            pkt_ready_and_o = ready_and_i;
            if (ready_and_i) begin
              byte_cnt_d = sum_s[cnt_w_lp-1:0];
              last_d     = pkt_last_i;
              state_d    = ST_DATA_RSP;
            end else begin
              state_d = ST_DATA;
            end
          end
        end else begin
          state_d = ST_DATA;
        end
      end
      ST_DATA_RSP: begin
        ready_and_o = 1'b1;
        if (valid_i) state_d = last_q ? ST_SIZE : ST_DATA;
        else         state_d = ST_DATA_RSP;
      end
      ST_SIZE: begin
        write_en_o   = 1'b1;
        addr_o       = tx_size_addr_p;
        write_data_o = data_width_p'(byte_cnt_q);
        if (ready_and_i) state_d = ST_SIZE_RSP;
        else             state_d = ST_SIZE;
      end
      ST_SIZE_RSP: begin
        ready_and_o = 1'b1;
        if (valid_i) state_d = ST_SEND;
        else         state_d = ST_SIZE_RSP;
      end
      ST_SEND: begin
        write_en_o   = 1'b1;
        addr_o       = tx_send_addr_p;
        write_data_o = data_width_p'(1);
        if (ready_and_i) state_d = ST_SEND_RSP;
        else             state_d = ST_SEND;
      end
      ST_SEND_RSP: begin
        ready_and_o = 1'b1;
        if (valid_i) begin
          done_d     = 1'b1;
          byte_cnt_d = '0;
          state_d    = ST_IDLE;
        end else begin
          state_d = ST_SEND_RSP;
        end
      end
      ST_DRAIN: begin
        pkt_ready_and_o = 1'b1;
        if (pkt_v_i && pkt_last_i) state_d = ST_DROP;
        else                       state_d = ST_DRAIN;
      end
      ST_DROP: begin
        byte_cnt_d = '0;
        state_d    = ST_IDLE;
      end
      default: begin
        byte_cnt_d = '0;
        state_d    = ST_IDLE;
      end
    endcase
  end

  // State, byte counter, last-word flag and done pulse registers.
  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      state_q    <= ST_IDLE;
      byte_cnt_q <= '0;
      last_q     <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      byte_cnt_q <= byte_cnt_d;
      last_q     <= last_d;
      done_q     <= done_d;
    end
  end

  assign op_size_o = (write_en_o | read_en_o) ? opsz_w_lp'($clog2(bytes_lp)) : '0;
  assign busy_o    = (state_q != ST_IDLE);
  assign done_o    = done_q;
  assign err_o     = (state_q == ST_DROP);

endmodule

// File: tb/tb_ethernet_tx_mmio_initiator.sv
// Directed bench for ethernet_tx_mmio_initiator with a behavioural MMIO
// responder that logs every accepted command.
module tb_ethernet_tx_mmio_initiator;

  typedef struct packed {
    logic        we;
    logic [13:0] addr;
    logic [31:0] data;
  } cmd_t;

  logic        clk = 1'b0;
  logic        reset_n_i;
  logic        pkt_v_i, pkt_last_i, pkt_ready_and_o;
  logic [31:0] pkt_data_i;
  logic [2:0]  pkt_bytes_i;
  logic [13:0] addr_o;
  logic        write_en_o, read_en_o, ready_and_i, valid_i, ready_and_o;
  logic [1:0]  op_size_o;
  logic [31:0] write_data_o, read_data_i;
  logic        busy_o, done_o, err_o;

  int   checks_n = 0;
  int   errors_n = 0;
  int   cyc = 0;
  cmd_t log_q[$];
  int   logc_q[$];
  int   rd_count = 0;
  int   busy_until = 0;
  int   stab_err = 0;
  int   done_cnt = 0;
  int   err_cnt = 0;
  int   v_cyc = 0;
  bit   stall_en = 1'b0;
  bit   abort = 1'b0;

  ethernet_tx_mmio_initiator dut (
    .clk_i           (clk),
    .reset_n_i       (reset_n_i),
    .pkt_v_i         (pkt_v_i),
    .pkt_data_i      (pkt_data_i),
    .pkt_last_i      (pkt_last_i),
    .pkt_bytes_i     (pkt_bytes_i),
    .pkt_ready_and_o (pkt_ready_and_o),
    .addr_o          (addr_o),
    .write_en_o      (write_en_o),
    .read_en_o       (read_en_o),
    .ready_and_i     (ready_and_i),
    .op_size_o       (op_size_o),
    .write_data_o    (write_data_o),
    .valid_i         (valid_i),
    .ready_and_o     (ready_and_o),
    .read_data_i     (read_data_i),
    .busy_o          (busy_o),
    .done_o          (done_o),
    .err_o           (err_o)
  );

  ethernet_tx_mmio_initiator_chk u_chk (
    .clk_i       (clk),
    .reset_n_i   (reset_n_i),
    .valid_i     (valid_i),
    .rsp_ready_i (ready_and_o)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks_n++;
    if (got !== exp) begin
      errors_n++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] word_f(input int id, input int k);
    return {8'hA5, 8'(id), 16'(k)};
  endfunction

  function automatic cmd_t mk_cmd(input logic we, input logic [13:0] addr, input logic [31:0] data);
    cmd_t c;
    c.we = we; c.addr = addr; c.data = data;
    return c;
  endfunction

  // Responder: drives ready/valid at negedge, logs accepted commands 1 time unit later.
  initial begin : responder
    bit          pend;
    logic [31:0] rsp_data;
    bit          have_prev;
    logic [47:0] prev;
    pend = 1'b0; rsp_data = '0; have_prev = 1'b0; prev = '0;
    ready_and_i = 1'b0; valid_i = 1'b0; read_data_i = '0;
    forever begin
      @(negedge clk);
      if (!reset_n_i) begin
        ready_and_i = 1'b0; valid_i = 1'b0; pend = 1'b0; have_prev = 1'b0;
      end else begin
        ready_and_i = stall_en ? 1'($urandom_range(0, 1)) : 1'b1;
        valid_i     = pend && (stall_en ? 1'($urandom_range(0, 1)) : 1'b1);
        read_data_i = rsp_data;
        #1;
        if (have_prev && (write_en_o || read_en_o) &&
            ({write_en_o, read_en_o, addr_o, write_data_o} != prev)) stab_err++;
        have_prev = 1'b0;
        if (valid_i && ready_and_o) pend = 1'b0;
        if ((write_en_o || read_en_o) && ready_and_i) begin
          log_q.push_back(mk_cmd(write_en_o, addr_o, write_data_o));
          logc_q.push_back(cyc);
          pend = 1'b1;
          if (read_en_o) begin
            rsp_data = (rd_count >= busy_until) ? 32'h0000_0001 : 32'h0000_0000;
            rd_count++;
          end else begin
            rsp_data = 32'h0;
          end
        end else if (write_en_o || read_en_o) begin
          have_prev = 1'b1;
          prev = {write_en_o, read_en_o, addr_o, write_data_o};
        end
      end
    end
  end

  // Pulse counters for done_o / err_o.
  initial begin : pulse_mon
    forever begin
      @(negedge clk);
      if (done_o) done_cnt++;
      if (err_o)  err_cnt++;
    end
  end

  task automatic send_pkt(input int nbytes, input int id);
    int nw, k, it;
    nw = (nbytes + 3) / 4; k = 0; it = 0;
    @(negedge clk);
    v_cyc = cyc;
    while (k < nw && !abort && it < 6000) begin
      pkt_v_i     = 1'b1;
      pkt_data_i  = word_f(id, k);
      pkt_last_i  = (k == nw - 1);
      pkt_bytes_i = (k == nw - 1) ? 3'(nbytes - 4 * k) : 3'd4;
      #1;
      if (pkt_ready_and_o) k++;
      it++;
      @(negedge clk);
    end
    pkt_v_i = 1'b0; pkt_last_i = 1'b0; pkt_bytes_i = 3'd0; pkt_data_i = 32'h0;
    if (!abort) check_eq("src_done", 64'(k), 64'(nw));
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    @(negedge clk);
    while (busy_o && n < 3000) begin
      @(negedge clk);
      n++;
    end
    check_eq("idle_timeout", 64'(busy_o), 64'(0));
  endtask

  // Compare logged commands from index base against the expected sequence.
  task automatic check_log(input string tag, input int base, input int nreads,
                           input int nbytes, input int id, input bit dropped);
    cmd_t exp_q[$];
    int   nw, cnt, b, n;
    bit   stop;
    nw = (nbytes + 3) / 4; cnt = 0; stop = 1'b0;
    for (int r = 0; r < nreads; r++) exp_q.push_back(mk_cmd(1'b0, 14'h0010, 32'h0));
    for (int k = 0; k < nw; k++) begin
      b = (k == nw - 1) ? nbytes - 4 * k : 4;
      if (cnt + b > 2048) stop = 1'b1;
      if (!stop) begin
        exp_q.push_back(mk_cmd(1'b1, 14'(32'h1800 + 4 * k), word_f(id, k)));
        cnt += b;
      end
    end
    if (!dropped) begin
      exp_q.push_back(mk_cmd(1'b1, 14'h0018, 32'(cnt)));
      exp_q.push_back(mk_cmd(1'b1, 14'h001C, 32'h1));
    end
    n = log_q.size() - base;
    check_eq($sformatf("%s_len", tag), 64'(n), 64'(exp_q.size()));
    for (int i = 0; i < n && i < exp_q.size(); i++)
      check_eq($sformatf("%s_cmd%0d", tag, i), 64'(log_q[base + i]), 64'(exp_q[i]));
  endtask

  initial begin : main
    int base, d0, e0, n;
    bit found;
    reset_n_i = 1'b0; pkt_v_i = 1'b0; pkt_last_i = 1'b0; pkt_bytes_i = 3'd0; pkt_data_i = 32'h0;
    #1;
    check_eq("reset_outputs", 64'({addr_o, write_en_o, read_en_o, op_size_o, write_data_o,
             ready_and_o, pkt_ready_and_o, busy_o, done_o, err_o}), 64'(0));
    repeat (3) @(negedge clk);
    reset_n_i = 1'b1;

    // 64-byte packet, status free, zero-wait responder.
    base = log_q.size(); d0 = done_cnt; e0 = err_cnt;
    send_pkt(64, 1);
    wait_idle();
    check_log("t64", base, 1, 64, 1, 1'b0);
    if (log_q.size() > base + 1) check_eq("latency", 64'(logc_q[base + 1] - v_cyc), 64'(3));
    check_eq("t64_done", 64'(done_cnt - d0), 64'(1));
    check_eq("t64_err", 64'(err_cnt - e0), 64'(0));

    // Status busy for three polls.
    base = log_q.size(); d0 = done_cnt;
    busy_until = rd_count + 3;
    send_pkt(16, 2);
    wait_idle();
    check_log("tpoll", base, 4, 16, 2, 1'b0);
    if (log_q.size() >= base + 5) begin
      for (int i = 1; i < 4; i++)
        check_eq($sformatf("poll_gap%0d", i), 64'((logc_q[base + i] - logc_q[base + i - 1]) >= 17), 64'(1));
      check_eq("poll_data_after_rsp", 64'((logc_q[base + 4] - logc_q[base + 3]) >= 2), 64'(1));
    end
    check_eq("tpoll_done", 64'(done_cnt - d0), 64'(1));

    // 61-byte packet with a 1-byte tail word.
    base = log_q.size(); d0 = done_cnt;
    send_pkt(61, 3);
    wait_idle();
    check_log("t61", base, 1, 61, 3, 1'b0);
    check_eq("t61_done", 64'(done_cnt - d0), 64'(1));

    // Over-MTU packet whose overflowing word is the last one.
    base = log_q.size(); d0 = done_cnt; e0 = err_cnt;
    send_pkt(2052, 4);
    wait_idle();
    check_log("t2052", base, 1, 2052, 4, 1'b1);
    check_eq("t2052_err", 64'(err_cnt - e0), 64'(1));
    check_eq("t2052_done", 64'(done_cnt - d0), 64'(0));

    // Next packet after the drop sends normally.
    base = log_q.size(); d0 = done_cnt;
    send_pkt(8, 5);
    wait_idle();
    check_log("tafter", base, 1, 8, 5, 1'b0);
    check_eq("tafter_done", 64'(done_cnt - d0), 64'(1));

    // Over-MTU packet that continues past the overflow (drain path).
    base = log_q.size(); d0 = done_cnt; e0 = err_cnt;
    send_pkt(2060, 6);
    wait_idle();
    check_log("t2060", base, 1, 2060, 6, 1'b1);
    check_eq("t2060_err", 64'(err_cnt - e0), 64'(1));
    check_eq("t2060_done", 64'(done_cnt - d0), 64'(0));

    // Random stalls: same command sequence as the zero-wait 64-byte run.
    base = log_q.size(); d0 = done_cnt;
    stall_en = 1'b1;
    send_pkt(64, 1);
    wait_idle();
    stall_en = 1'b0;
    check_log("tstall", base, 1, 64, 1, 1'b0);
    check_eq("cmd_stable", 64'(stab_err), 64'(0));
    check_eq("tstall_done", 64'(done_cnt - d0), 64'(1));

    // Reset during the 5th data write.
    abort = 1'b0;
    fork
      send_pkt(64, 7);
    join_none
    n = 0; found = 1'b0;
    while (!found && n < 500) begin
      @(negedge clk);
      #2;
      if (write_en_o && addr_o == 14'h1810) found = 1'b1;
      n++;
    end
    check_eq("rst_5th_write_seen", 64'(found), 64'(1));
    reset_n_i = 1'b0;
    #1;
    check_eq("rst_outputs_async", 64'({addr_o, write_en_o, read_en_o, op_size_o, write_data_o,
             ready_and_o, pkt_ready_and_o, busy_o, done_o, err_o}), 64'(0));
    abort = 1'b1;
    repeat (3) @(negedge clk);
    abort = 1'b0;
    reset_n_i = 1'b1;
    base = log_q.size(); d0 = done_cnt;
    send_pkt(16, 8);
    wait_idle();
    check_log("trst", base, 1, 16, 8, 1'b0);
    check_eq("trst_done", 64'(done_cnt - d0), 64'(1));

    $display("Simulation finished: %0d checks, %0d errors", checks_n, errors_n);
    $finish;
  end

endmodule
